multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Multi-cycle MIPS main control FSM.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the 3-bit ALUOp consumed by the ALU control stage, plus all datapath mux, enable and memory strobes.
- Sits between the instruction register opcode field and the datapath; stalls on a memory-ready handshake.

Parameters:
- STATE_W, 4, width of state register and debug state port.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- opcode  input  6  IR[31:26]; stable from the cycle after the FETCH ir_write until the next FETCH.
- mem_ready  input  1  memory completes the current read/write this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero.
- pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- i_or_d  output  1  memory address: 0 PC, 1 ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  instruction register load.
- mem_to_reg  output  1  register write data: 1 MDR, 0 ALUOut.
- reg_dst  output  1  destination register: 1 rd, 0 rt.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A input: 0 PC, 1 register A.
- alu_src_b  output  2  ALU B input: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate.
- alu_op  output  3  ALUOp to the ALU control stage.
- instr_done  output  1  one-cycle pulse when an instruction retires.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- state  output  STATE_W  current state, for debug.

Behaviour:
- Reset: async assert forces state INIT immediately, from any state, including mid-memory-access. In INIT every output is 0.
- INIT always advances to FETCH on the next clock.
- Outputs are decoded combinationally from the state register. Exceptions: ir_write and pc_write in FETCH, and the MEM_READ/MEM_WRITE exits, are additionally qualified by mem_ready.
- Any output not listed for a state is 0 in that state.
- ALUOp encoding: 000 add (LW/SW/PC+4), 001 sub (BEQ), 010 R-type funct, 101 ANDI, 110 ADDI, 111 ORI.
- States, their encodings, outputs and transitions:
  - INIT (0): all outputs 0 -> FETCH.
  - FETCH (1): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00. ir_write=pc_write=mem_ready. Hold while mem_ready=0; -> DECODE when mem_ready=1.
  - DECODE (2): alu_src_a=0, alu_src_b=11, alu_op=000. Next state by opcode:
    - 100011/101011 -> MEM_ADDR
    - 000000 -> R_EXEC
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000/001100/001101 -> I_EXEC
    - otherwise -> FETCH, with illegal_op=1 this cycle.
  - MEM_ADDR (3): alu_src_a=1, alu_src_b=10, alu_op=000. -> MEM_READ if opcode=100011, else MEM_WRITE.
  - MEM_READ (4): mem_read=1, i_or_d=1. Hold until mem_ready, then -> MEM_WB.
  - MEM_WB (5): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
  - MEM_WRITE (6): mem_write=1, i_or_d=1. Hold until mem_ready; on mem_ready, instr_done=1 -> FETCH.
  - R_EXEC (7): alu_src_a=1, alu_src_b=00, alu_op=010 -> R_WB.
  - R_WB (8): reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
  - BRANCH (9): alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01, instr_done=1 -> FETCH.
  - JUMP (10): pc_write=1, pc_source=10, instr_done=1 -> FETCH.
  - I_EXEC (11): alu_src_a=1, alu_src_b=10; alu_op=110 (001000), 101 (001100), 111 (001101) -> I_WB.
  - I_WB (12): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
  - Encodings 13-15: unreachable. If entered, all outputs 0 and -> FETCH next cycle.
- Latency in cycles, with zero memory wait:
  - LW 5
  - SW 4
  - R-type / I-type 4
  - BEQ 3
  - J 3
  - Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- mem_read and mem_write are never asserted in the same cycle. reg_write and any memory strobe are never asserted in the same cycle.
- Opcode is sampled only in DECODE, MEM_ADDR and I_EXEC.

Test Plan:
- reset_n low for 2 clocks, released -> all outputs 0 in INIT; next cycle state=1, mem_read=1, alu_src_b=01.
- mem_ready=1 always; opcode=100011 -> states 1,2,3,4,5,1. alu_op=000 in MEM_ADDR; reg_write=1 and mem_to_reg=1 in state 5; instr_done pulses once.
- opcode=000000 -> alu_op=010 in state 7; reg_dst=1, reg_write=1 in state 8. Then opcode=001101 -> alu_op=111 in state 11. Then opcode=001100 -> alu_op=101.
- opcode=000100 -> state 9 with alu_op=001, pc_write_cond=1, pc_source=01. Then opcode=000010 -> state 10 with pc_write=1, pc_source=10.
- SW with mem_ready low for 3 cycles in MEM_WRITE -> mem_write held 4 cycles; instr_done in the mem_ready cycle only. FETCH with mem_ready low for 2 cycles -> ir_write=0 until the ready cycle.
- opcode=111111 -> illegal_op pulse in DECODE, then FETCH. Separately, reset_n asserted mid-MEM_READ -> mem_read drops to 0 asynchronously, state=0.

Source files
------------

// File: rtl/multicycle_main_control.sv
// Multi-cycle MIPS main control FSM: steps each instruction through fetch, decode,
// execute, memory and writeback, driving datapath selects, enables and ALUOp.
module multicycle_main_control #(
    parameter int STATE_W = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    localparam logic [STATE_W-1:0] S_INIT      = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_FETCH     = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_DECODE    = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEM_ADDR  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEM_READ  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEM_WB    = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_MEM_WRITE = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_R_EXEC    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_R_WB      = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BRANCH    = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_JUMP      = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_I_EXEC    = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_I_WB      = STATE_W'(12);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:             state_d = S_MEM_ADDR;
                    OP_RTYPE:                 state_d = S_R_EXEC;
                    OP_BEQ:                   state_d = S_BRANCH;
                    OP_J:                     state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_I_EXEC;
                    default:                  state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            // INIT, all writeback/branch/jump states and the unused codes return to fetch
            default:     state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J,
                    OP_ADDI, OP_ANDI, OP_ORI: illegal_op = 1'b0;
                    default:                  illegal_op = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b001;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_ADDI: alu_op = 3'b110;
                    OP_ANDI: alu_op = 3'b101;
                    default: alu_op = 3'b111;
                endcase
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: directed literal checks followed by random
// opcode / mem_ready traffic compared every cycle against an instruction-path model.
module tb_multicycle_main_control;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    multicycle_main_control #(.STATE_W(4)) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    always #5 clock = ~clock;

    logic [22:0] dut_vec;
    assign dut_vec = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                      ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                      alu_op, instr_done, illegal_op, state};

    // Instruction classes: 0 LW, 1 SW, 2 R, 3 BEQ, 4 J, 5 I-type, 6 illegal
    function automatic int op_class(logic [5:0] op);
        case (op)
            6'b100011: return 0;
            6'b101011: return 1;
            6'b000000: return 2;
            6'b000100: return 3;
            6'b000010: return 4;
            6'b001000, 6'b001100, 6'b001101: return 5;
            default: return 6;
        endcase
    endfunction

    function automatic int base_latency(logic [5:0] op);
        case (op_class(op))
            0: return 5;
            1, 2, 5: return 4;
            default: return 3;
        endcase
    endfunction

    function automatic logic [22:0] exp_vec(int st, logic [5:0] op, logic rdy);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, done, ill;
        logic [1:0] ps, asb;
        logic [2:0] aop;
        logic [3:0] s4;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, done, ill} = '0;
        ps = 2'b00; asb = 2'b00; aop = 3'b000;
        s4 = 4'(st);
        case (st)
            1:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            2:  begin asb = 2'b11; ill = (op_class(op) == 6); end
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mr = 1; iod = 1; end
            5:  begin rw = 1; m2r = 1; done = 1; end
            6:  begin mw = 1; iod = 1; done = rdy; end
            7:  begin asa = 1; aop = 3'b010; end
            8:  begin rw = 1; rd = 1; done = 1; end
            9:  begin asa = 1; aop = 3'b001; pwc = 1; ps = 2'b01; done = 1; end
            10: begin pw = 1; ps = 2'b10; done = 1; end
            11: begin
                asa = 1; asb = 2'b10;
                aop = (op == 6'b001000) ? 3'b110 : (op == 6'b001100) ? 3'b101 : 3'b111;
            end
            12: begin rw = 1; done = 1; end
            default: ;
        endcase
        return {pw, pwc, ps, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, done, ill, s4};
    endfunction

    // Model: once fetch completes, queue the remaining steps of the instruction's path.
    int m_state = 0;
    int seq[$];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0;
            seq.delete();
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (mem_ready) begin
                seq.delete();
                case (op_class(opcode))
                    0: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); seq.push_back(5); end
                    1: begin seq.push_back(2); seq.push_back(3); seq.push_back(6); end
                    2: begin seq.push_back(2); seq.push_back(7); seq.push_back(8); end
                    3: begin seq.push_back(2); seq.push_back(9); end
                    4: begin seq.push_back(2); seq.push_back(10); end
                    5: begin seq.push_back(2); seq.push_back(11); seq.push_back(12); end
                    default: seq.push_back(2);
                endcase
                m_state = seq.pop_front();
            end
        end else if ((m_state == 4 || m_state == 6) && !mem_ready) begin
            m_state = m_state;
        end else if (seq.size() == 0) begin
            m_state = 1;
        end else begin
            m_state = seq.pop_front();
        end
    end

    int prev_state = 0;
    int cyc = 0;
    int waits = 0;

    always @(negedge clock) begin
        logic [22:0] e;
        e = exp_vec(m_state, opcode, mem_ready);
        checks++;
        if (dut_vec !== e) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t model_state=%0d actual=%h required=%h", $time, m_state, dut_vec, e);
        end
        checks++;
        if ((mem_read && mem_write) || (reg_write && (mem_read || mem_write))) begin
            failures++;
            $display("FAIL strobe_excl t=%0t actual mr=%b mw=%b rw=%b required exclusive", $time, mem_read, mem_write, reg_write);
        end
        if (!reset_n) begin
            prev_state = 0;
        end else begin
            if (m_state == 1 && prev_state != 1) begin
                cyc = 1;
                waits = mem_ready ? 0 : 1;
            end else begin
                cyc++;
                if ((m_state == 1 || m_state == 4 || m_state == 6) && !mem_ready) waits++;
            end
            if (instr_done) begin
                checks++;
                if (cyc != base_latency(opcode) + waits) begin
                    failures++;
                    $display("FAIL latency op=%b actual=%0d required=%0d", opcode, cyc, base_latency(opcode) + waits);
                end else begin
                    $display("retire op=%b cycles=%0d waits=%0d", opcode, cyc, waits);
                end
            end
            prev_state = m_state;
        end
    end

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [5:0] op_tab [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                               6'b000010, 6'b001000, 6'b001100, 6'b001101};

    initial begin
        reset_n = 1'b0; mem_ready = 1'b1; opcode = 6'b100011;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_outs", int'(dut_vec[22:4]), 0);
        reset_n = 1'b1;
        #1 chk("init_hold", int'(state), 0);
        tick();
        chk("fetch_state", int'(state), 1);
        chk("fetch_mem_read", int'(mem_read), 1);
        chk("fetch_alu_src_b", int'(alu_src_b), 1);

        // LW, zero wait
        tick(); chk("lw_s2", int'(state), 2);
        tick(); chk("lw_s3", int'(state), 3); chk("lw_aluop", int'(alu_op), 0);
        tick(); chk("lw_s4", int'(state), 4);
        tick(); chk("lw_s5", int'(state), 5);
        chk("lw_regw", int'(reg_write), 1); chk("lw_m2r", int'(mem_to_reg), 1);
        chk("lw_done", int'(instr_done), 1);
        tick(); chk("lw_back", int'(state), 1); chk("lw_done_off", int'(instr_done), 0);

        // R-type, ORI, ANDI
        opcode = 6'b000000;
        tick(); chk("r_s2", int'(state), 2);
        tick(); chk("r_s7", int'(state), 7); chk("r_aluop", int'(alu_op), 2);
        tick(); chk("r_s8", int'(state), 8); chk("r_regdst", int'(reg_dst), 1);
        chk("r_regw", int'(reg_write), 1);
        tick(); chk("r_back", int'(state), 1);
        opcode = 6'b001101;
        tick(); tick(); chk("ori_s11", int'(state), 11); chk("ori_aluop", int'(alu_op), 7);
        tick(); chk("ori_s12", int'(state), 12);
        tick();
        opcode = 6'b001100;
        tick(); tick(); chk("andi_s11", int'(state), 11); chk("andi_aluop", int'(alu_op), 5);
        tick(); tick(); chk("andi_back", int'(state), 1);

        // BEQ then J
        opcode = 6'b000100;
        tick(); tick(); chk("beq_s9", int'(state), 9); chk("beq_aluop", int'(alu_op), 1);
        chk("beq_pwc", int'(pc_write_cond), 1); chk("beq_pcsrc", int'(pc_source), 1);
        tick(); chk("beq_back", int'(state), 1);
        opcode = 6'b000010;
        tick(); tick(); chk("j_s10", int'(state), 10); chk("j_pw", int'(pc_write), 1);
        chk("j_pcsrc", int'(pc_source), 2);
        tick(); chk("j_back", int'(state), 1);

        // SW with 3 wait cycles in MEM_WRITE
        opcode = 6'b101011;
        tick(); tick(); chk("sw_s3", int'(state), 3);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sw_wait_state", int'(state), 6); chk("sw_wait_mw", int'(mem_write), 1);
            chk("sw_wait_done", int'(instr_done), 0);
        end
        mem_ready = 1'b1;
        #1 chk("sw_ready_mw", int'(mem_write), 1); chk("sw_ready_done", int'(instr_done), 1);
        tick(); chk("sw_back", int'(state), 1);

        // FETCH stalled 2 cycles, then an illegal opcode
        mem_ready = 1'b0;
        #1 chk("fw_irw0", int'(ir_write), 0);
        tick(); chk("fw_hold", int'(state), 1); chk("fw_irw1", int'(ir_write), 0);
        tick(); chk("fw_hold2", int'(state), 1);
        opcode = 6'b111111; mem_ready = 1'b1;
        #1 chk("fw_irw_rdy", int'(ir_write), 1); chk("fw_pw_rdy", int'(pc_write), 1);
        tick(); chk("ill_s2", int'(state), 2); chk("ill_pulse", int'(illegal_op), 1);
        tick(); chk("ill_back", int'(state), 1); chk("ill_off", int'(illegal_op), 0);

        // Async reset in the middle of MEM_READ
        opcode = 6'b100011;
        tick(); tick();
        mem_ready = 1'b0;
        tick(); chk("mr_s4", int'(state), 4); chk("mr_strobe", int'(mem_read), 1);
        #2 reset_n = 1'b0;
        #1 chk("arst_mr", int'(mem_read), 0); chk("arst_state", int'(state), 0);
        tick();
        reset_n = 1'b1; mem_ready = 1'b1;

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            tick();
            mem_ready = ($urandom_range(0, 3) != 0);
            if (m_state == 1) begin
                if ($urandom_range(0, 7) == 0) opcode = 6'($urandom);
                else opcode = op_tab[$urandom_range(0, 7)];
            end
            if ($urandom_range(0, 799) == 0) begin
                #2 reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
        end
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
